pwm_duty_driver: RTL

Downstream stage of the gain multiplier in the temperature-control path. Takes the signed 32-bit scaled control product, rescales it by a fixed arithmetic right shift, and saturates it to a PWM duty value. It then drives the heater/fan PWM output with glitch-free duty updates that take effect only at period boundaries.

---
 rtl/pwm_duty_driver_pkg.sv | 13 +
 rtl/duty_saturator.sv | 39 +++
 rtl/pwm_duty_driver.sv | 91 +++++++++
 3 files changed

// File: rtl/pwm_duty_driver_pkg.sv
// Shared control constants and state type for the temperature PWM path.
// The gain multiplier reuses the same period and fraction-bit defaults.
package pwm_duty_driver_pkg;

   localparam int PWM_PERIOD_W   = 10;
   localparam int GAIN_FRAC_BITS = 11;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/duty_saturator.sv
// Drops the fixed-point fraction from the product, then clamps the result
// to the duty range 0..2^PERIOD_W, flagging which side was clipped.
module duty_saturator
   import pwm_duty_driver_pkg::*;
#(
   parameter int PERIOD_W = PWM_PERIOD_W,
   parameter int SHIFT    = GAIN_FRAC_BITS
) (
   input  logic signed [31:0]     product,
   output logic [PERIOD_W:0]      duty,
   output logic                   hi,
   output logic                   lo
);

   localparam logic signed [31:0] FULL = 32'sd1 <<< PERIOD_W;

   logic signed [31:0] s;

   assign s = product >>> SHIFT;

   always_comb begin
      duty = '0;
      hi   = 1'b0;
      lo   = 1'b0;
      unique case (1'b1)
         (s < 0): begin
            lo = 1'b1;
         end
         (s > FULL): begin
            duty = FULL[PERIOD_W:0];
            hi   = 1'b1;
         end
         default: begin
            duty = s[PERIOD_W:0];
         end
      endcase
   end

endmodule

// File: rtl/pwm_duty_driver.sv
// Captures saturated duty samples and drives a PWM output whose duty
// changes only at the wrap edge, so no period is ever truncated.
module pwm_duty_driver
   import pwm_duty_driver_pkg::*;
#(
   parameter int PERIOD_W = PWM_PERIOD_W,
   parameter int SHIFT    = GAIN_FRAC_BITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  product_valid,
   input  logic signed [31:0]    product,
   input  logic                  enable,
   output logic                  pwm_out,
   output logic [PERIOD_W:0]     duty_active,
   output logic                  period_tick,
   output logic                  sat_hi,
   output logic                  sat_lo
);

   localparam logic [PERIOD_W-1:0] LAST = '1;

   state_t              state;
   logic [PERIOD_W-1:0] cnt;
   logic [PERIOD_W:0]   pend;
   logic                pend_flag;
   logic [PERIOD_W:0]   new_duty;
   logic                new_hi;
   logic                new_lo;
   logic                last;

   duty_saturator #(
      .PERIOD_W (PERIOD_W),
      .SHIFT    (SHIFT)
   ) u_sat (
      .product (product),
      .duty    (new_duty),
      .hi      (new_hi),
      .lo      (new_lo)
   );

   assign last = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         duty_active <= '0;
         pend        <= '0;
         pend_flag   <= 1'b0;
         pwm_out     <= 1'b0;
         period_tick <= 1'b0;
         sat_hi      <= 1'b0;
         sat_lo      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt         <= '0;
               pwm_out     <= 1'b0;
               period_tick <= 1'b0;
               if (enable) state <= RUN;
            end
            RUN: begin
               if (!enable) begin
                  state       <= IDLE;
                  cnt         <= '0;
                  pwm_out     <= 1'b0;
                  period_tick <= 1'b0;
               end else begin
                  cnt         <= cnt + 1'b1;
                  pwm_out     <= ({1'b0, cnt} < duty_active);
                  period_tick <= last;
                  if (last && pend_flag) begin
                     duty_active <= pend;
                     pend_flag   <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
         // A capture on the wrap edge re-arms the flag after the apply.
         if (product_valid) begin
            pend      <= new_duty;
            pend_flag <= 1'b1;
            sat_hi    <= new_hi;
            sat_lo    <= new_lo;
         end
      end
   end

endmodule
